// File: rtl/stopwatch_mmss.sv
// stopwatch_mmss: start/stop + clear stopwatch with a BCD digit chain and per-digit 7-segment output.
// Define STOPWATCH_LAP_EN to add the lap button and the frozen-display snapshot.
module stopwatch_mmss #(
  parameter int                CLK_HZ         = 26_000_000,
  parameter int                TICK_HZ        = 100,
  parameter int                DIGITS         = 6,
  parameter logic [DIGITS-1:0] MOD6_MASK      = 6'b101000,
  parameter bit                SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_stop,
  input  logic                clear,
`ifdef STOPWATCH_LAP_EN
  input  logic                lap,
`endif
  output logic [7*DIGITS-1:0] hex,
  output logic                running,
  output logic                overflow
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic [2:0]             ss_sync;
  logic [2:0]             cl_sync;
  logic                   ss_pulse;
  logic                   cl_pulse;
  logic                   clear_ok;
  logic                   tick;
  logic                   wrap;
  logic [PW-1:0]          presc;
  logic [DIGITS-1:0][3:0] digits;
  logic [DIGITS-1:0][3:0] digits_next;
  logic [DIGITS-1:0][3:0] shown;

  // Raw pins: three flops, rising-edge pulse taken between stages 1 and 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_sync <= '0;
      cl_sync <= '0;
    end else begin
      ss_sync <= {ss_sync[1:0], start_stop};
      cl_sync <= {cl_sync[1:0], clear};
    end
  end

  assign ss_pulse = ss_sync[1] & ~ss_sync[2];
  assign cl_pulse = cl_sync[1] & ~cl_sync[2];
  assign clear_ok = cl_pulse & ~running;
  assign tick     = running & (presc == PRESC_MAX);

  // Ripple enable: a digit moves when the tick reaches it through all-max lower digits.
  always_comb begin
    logic carry;
    logic at_max;
    carry       = tick;
    at_max      = 1'b0;
    digits_next = digits;
    for (int i = 0; i < DIGITS; i++) begin
      at_max = (digits[i] == (MOD6_MASK[i] ? 4'd5 : 4'd9));
      if (carry) digits_next[i] = at_max ? 4'd0 : digits[i] + 4'd1;
      carry = carry & at_max;
    end
    wrap = carry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running  <= 1'b0;
      presc    <= '0;
      digits   <= '0;
      overflow <= 1'b0;
    end else begin
      running <= running ^ ss_pulse;
      if (clear_ok) begin
        presc    <= '0;
        digits   <= '0;
        overflow <= 1'b0;
      end else if (running) begin
        presc  <= tick ? '0 : presc + 1'b1;
        digits <= digits_next;
        if (wrap) overflow <= 1'b1;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [2:0]             lp_sync;
  logic                   lp_pulse;
  logic                   frozen;
  logic [DIGITS-1:0][3:0] snapshot;

  assign lp_pulse = lp_sync[1] & ~lp_sync[2];

  // Stopping keeps the freeze; only a second lap or an accepted clear releases it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lp_sync  <= '0;
      frozen   <= 1'b0;
      snapshot <= '0;
    end else begin
      lp_sync <= {lp_sync[1:0], lap};
      if (clear_ok) begin
        frozen <= 1'b0;
      end else if (lp_pulse) begin
        if (frozen) begin
          frozen <= 1'b0;
        end else if (running) begin
          snapshot <= digits;
          frozen   <= 1'b1;
        end
      end
    end
  end

  assign shown = frozen ? snapshot : digits;
`else
  assign shown = digits;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    assign hex[7*i +: 7] = SEG_ACTIVE_LOW ? seg7(shown[i]) : ~seg7(shown[i]);
  end
endmodule

// File: tb/tb_stopwatch_mmss.sv
// Bench for stopwatch_mmss: random button traffic against a tick-count reference model,
// scoreboarded per clock on {hex, running, overflow}.
module tb_stopwatch_mmss;
  localparam int                CLK_HZ = 1000;
  localparam int                TICK_HZ = 100;
  localparam int                DIV = CLK_HZ / TICK_HZ;
  localparam int                DIGITS = 3;
  localparam logic [DIGITS-1:0] MASK = 3'b100;
  localparam int                W = 7 * DIGITS + 2;

  logic               clk;
  logic               reset;
  logic               start_stop;
  logic               clear;
`ifdef STOPWATCH_LAP_EN
  logic               lap;
`endif
  logic [7*DIGITS-1:0] hex;
  logic               running;
  logic               overflow;

  logic [W-1:0] exp_q[$];
  int vectors;
  int miscompares;

  // Reference model: elapsed time as a plain tick count, wrapping at the product of the moduli.
  int       full_count;
  int       m_count;
  int       m_presc;
  int       m_snap;
  bit       m_run;
  bit       m_ovf;
  bit       m_frozen;
  bit [3:0] h_ss;
  bit [3:0] h_cl;
  bit [3:0] h_lp;

  stopwatch_mmss #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DIGITS(DIGITS),
    .MOD6_MASK(MASK), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
    .lap(lap),
`endif
    .hex(hex), .running(running), .overflow(overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got running=%b, required test end", running);
    $fatal(1, "watchdog");
  end

  function automatic int modulus(int i);
    logic [DIGITS-1:0] m;
    m = MASK;
    return m[i] ? 6 : 10;
  endfunction

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_count = 0; m_presc = 0; m_snap = 0;
    m_run = 0; m_ovf = 0; m_frozen = 0;
    h_ss = '0; h_cl = '0; h_lp = '0;
  endtask

  // One rising edge: pulses come from the raw level two and three edges back.
  task automatic model_step();
    bit p_ss, p_cl, p_lp, clr_ok, tick;
    h_ss = {h_ss[2:0], start_stop};
    h_cl = {h_cl[2:0], clear};
`ifdef STOPWATCH_LAP_EN
    h_lp = {h_lp[2:0], lap};
`endif
    p_ss = h_ss[2] & ~h_ss[3];
    p_cl = h_cl[2] & ~h_cl[3];
    p_lp = h_lp[2] & ~h_lp[3];
    clr_ok = p_cl && !m_run;
    tick = m_run && (m_presc == DIV - 1);
    if (p_lp) begin
      if (m_frozen) m_frozen = 0;
      else if (m_run) begin m_snap = m_count; m_frozen = 1; end
    end
    if (clr_ok) begin
      m_count = 0; m_presc = 0; m_ovf = 0; m_frozen = 0;
    end else if (m_run) begin
      if (tick) begin
        m_presc = 0;
        m_count = m_count + 1;
        if (m_count == full_count) begin m_count = 0; m_ovf = 1; end
      end else begin
        m_presc = m_presc + 1;
      end
    end
    m_run = m_run ^ p_ss;
  endtask

  task automatic push_exp();
    logic [7*DIGITS-1:0] h;
    int v;
    v = m_frozen ? m_snap : m_count;
    for (int i = 0; i < DIGITS; i++) begin
      h[7*i +: 7] = seg_of(v % modulus(i));
      v = v / modulus(i);
    end
    exp_q.push_back({h, m_run, m_ovf});
  endtask

  // Driver tasks
  task automatic step_cycles(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      push_exp();
      #1;
    end
  endtask

  task automatic do_reset(int n);
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_stop = 1'b0;
    clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    model_reset();
    push_exp();
    repeat (n) begin
      @(posedge clk);
      push_exp();
    end
    #1;
    reset = 1'b1;
  endtask

  task automatic press(bit ss, bit cl, int hold);
    start_stop = ss;
    clear = cl;
    step_cycles(hold);
    start_stop = 1'b0;
    clear = 1'b0;
    step_cycles(4);
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic press_lap(int hold);
    lap = 1'b1;
    step_cycles(hold);
    lap = 1'b0;
    step_cycles(4);
  endtask
`endif

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({hex, running, overflow} !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: hex=%h running=%b overflow=%b, required hex=%h running=%b overflow=%b",
                 $time, hex, running, overflow, e[W-1:2], e[1], e[0]);
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    full_count = 1;
    for (int i = 0; i < DIGITS; i++) full_count = full_count * modulus(i);
    reset = 1'b0;
    start_stop = 1'b0;
    clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    model_reset();

    do_reset(3);
    step_cycles(1000);            // idle: display stays at zero
    press(1, 0, 1);               // start
    step_cycles(250);
    press(0, 1, 2);               // clear while running is ignored
    step_cycles(50);
`ifdef STOPWATCH_LAP_EN
    step_cycles(1230 - 10 * (m_count % 123));
    press_lap(1);                 // freeze the display
    step_cycles(300);
    press_lap(2);                 // release
    step_cycles(40);
    press_lap(1);                 // freeze again, survives the stop below
`endif
    press(1, 0, 3);               // stop, held several cycles
    step_cycles(500);
    press(0, 1, 1);               // clear while stopped
    step_cycles(20);
    press(1, 1, 1);               // both while stopped: zero and start
    step_cycles(100);
    press(1, 1, 1);               // both while running: stop only
    step_cycles(30);
    press(1, 0, 1);               // resume from a partial prescale
    step_cycles(full_count * DIV + 150);  // through a full wrap
    press(1, 0, 1);
    press(0, 1, 1);               // overflow cleared
    press(1, 0, 1);
    step_cycles(137);
    do_reset(2);                  // reset mid-count
    step_cycles(50);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 7))
        0: press(1, 0, $urandom_range(1, 4));
        1: press(0, 1, $urandom_range(1, 4));
        2: press(1, 1, $urandom_range(1, 3));
`ifdef STOPWATCH_LAP_EN
        3: press_lap($urandom_range(1, 3));
`else
        3: step_cycles($urandom_range(1, 40));
`endif
        4, 5: step_cycles($urandom_range(1, 400));
        6: begin
          for (int k = $urandom_range(1, 6); k > 0; k--) begin
            start_stop = 1'($urandom_range(0, 1));
            clear = 1'($urandom_range(0, 1));
            step_cycles(1);
          end
          start_stop = 1'b0;
          clear = 1'b0;
          step_cycles(4);
        end
        default: begin
          if ($urandom_range(0, 3) == 0) do_reset($urandom_range(0, 2));
          step_cycles($urandom_range(1, 20));
        end
      endcase
    end

    step_cycles(5);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
